// File: rtl/fft_iter_core.sv
// fft_iter_core: iterative radix-2 DIT FFT/IFFT engine.
//   One complex sample per cycle is streamed in and stored at its bit-reversed
//   address. The engine then computes in place at one butterfly per cycle and
//   streams the results out in natural order. inv selects an inverse transform
//   for the whole frame; the inverse halves every stage, so the total scale is 1/N.
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   inv                inverse select, latched with the first sample of a frame
//   in_valid/in_ready  input handshake; in_re/in_im signed samples (Q.3)
//   out_valid/out_ready output handshake; out_re/out_im results, out_last on index N-1
//   busy               high while computing or unloading
module fft_iter_core #(
    parameter int N_POINTS = 8,
    parameter int DATA_W   = 9,
    parameter int TW_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inv,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_last,
    output logic              busy
);
    localparam int LOG2N = (N_POINTS == 16) ? 4 : 3;
    localparam int AW    = LOG2N;
    localparam int KW    = LOG2N - 1;
    localparam int FRAC  = TW_W - 2;
    localparam int P_W   = DATA_W + TW_W + 1;
    // Two guard bits so top+t never wraps before saturation.
    localparam int S_W   = DATA_W + 2;

    // Twiddle magnitudes for angles that are multiples of pi/8, rounded to nearest.
    localparam longint ONE = longint'(1) << FRAC;
    localparam logic signed [TW_W-1:0] T_ONE = TW_W'(ONE);
    localparam logic signed [TW_W-1:0] T_C4  = TW_W'((ONE * 46341 + 32768) >>> 16);
    localparam logic signed [TW_W-1:0] T_C8  = TW_W'((ONE * 60547 + 32768) >>> 16);
    localparam logic signed [TW_W-1:0] T_S8  = TW_W'((ONE * 25080 + 32768) >>> 16);
    localparam logic signed [S_W-1:0]  SMAX  = S_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [S_W-1:0]  SMIN  = S_W'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    state_t state, state_nx;

    logic [AW-1:0] cnt;      // load index, then unload index
    logic [KW-1:0] bf_k;     // butterfly within stage
    logic [1:0]    stg;      // stage
    logic          inv_q;
    logic          bf_last, stg_last, out_adv;

    logic signed [DATA_W-1:0] mem_re [N_POINTS];
    logic signed [DATA_W-1:0] mem_im [N_POINTS];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [S_W-1:0] v);
        if (v > SMAX) return {1'b0, {(DATA_W-1){1'b1}}};
        if (v < SMIN) return {1'b1, {(DATA_W-1){1'b0}}};
        return v[DATA_W-1:0];
    endfunction

    // Butterfly addressing
    logic [AW-1:0] k_ext, span, pos, top, bot;
    logic [2:0]    tw_m;     // twiddle angle in units of pi/8

    always_comb begin
        k_ext = AW'(bf_k);
        span  = AW'(1) << stg;
        pos   = k_ext & (span - AW'(1));
        top   = ((k_ext & ~(span - AW'(1))) << 1) | pos;
        bot   = top + span;
        // idx*2pi/N == (pos << (3-stg)) * pi/8 for both N=8 and N=16
        tw_m  = 3'(pos << (2'd3 - stg));
    end

    logic signed [TW_W-1:0] w_cos, w_sin, w_re, w_im;

    always_comb begin
        w_cos = T_ONE;
        w_sin = '0;
        case (tw_m)
            3'd0: begin w_cos = T_ONE;  w_sin = '0;    end
            3'd1: begin w_cos = T_C8;   w_sin = T_S8;  end
            3'd2: begin w_cos = T_C4;   w_sin = T_C4;  end
            3'd3: begin w_cos = T_S8;   w_sin = T_C8;  end
            3'd4: begin w_cos = '0;     w_sin = T_ONE; end
            3'd5: begin w_cos = -T_S8;  w_sin = T_C8;  end
            3'd6: begin w_cos = -T_C4;  w_sin = T_C4;  end
            default: begin w_cos = -T_C8; w_sin = T_S8; end
        endcase
        w_re = w_cos;
        w_im = inv_q ? w_sin : -w_sin;   // inverse uses the conjugate
    end

    logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
    logic signed [P_W-1:0]    p_re, p_im;
    logic signed [S_W-1:0]    t_re, t_im, s_re, s_im, d_re, d_im;
    logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

    always_comb begin
        a_re = mem_re[top];
        a_im = mem_im[top];
        b_re = mem_re[bot];
        b_im = mem_im[bot];
        p_re = P_W'(b_re) * P_W'(w_re) - P_W'(b_im) * P_W'(w_im);
        p_im = P_W'(b_re) * P_W'(w_im) + P_W'(b_im) * P_W'(w_re);
        t_re = S_W'(p_re >>> FRAC);
        t_im = S_W'(p_im >>> FRAC);
        s_re = S_W'(a_re) + t_re;
        s_im = S_W'(a_im) + t_im;
        d_re = S_W'(a_re) - t_re;
        d_im = S_W'(a_im) - t_im;
        if (inv_q) begin
            s_re = s_re >>> 1;
            s_im = s_im >>> 1;
            d_re = d_re >>> 1;
            d_im = d_im >>> 1;
        end
        top_re = sat(s_re);
        top_im = sat(s_im);
        bot_re = sat(d_re);
        bot_im = sat(d_im);
    end

    assign bf_last  = (bf_k == {KW{1'b1}});
    assign stg_last = (stg == 2'(LOG2N - 1));
    // Present a new sample when the output register is empty or being drained,
    // but never past the one flagged last.
    assign out_adv  = (state == S_UNLOAD) && (!out_valid || (out_ready && !out_last));

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == AW'(N_POINTS - 1)) state_nx = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (bf_last && stg_last) state_nx = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last) state_nx = S_LOAD;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_LOAD;
            cnt       <= '0;
            bf_k      <= '0;
            stg       <= '0;
            inv_q     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_LOAD: if (in_valid) begin
                    if (cnt == '0) inv_q <= inv;
                    cnt <= cnt + AW'(1);     // wraps to 0 after the last sample
                end
                S_COMPUTE: begin
                    bf_k <= bf_k + KW'(1);
                    if (bf_last) stg <= stg_last ? 2'd0 : stg + 2'd1;
                end
                S_UNLOAD: begin
                    if (out_adv) begin
                        out_valid <= 1'b1;
                        out_re    <= mem_re[cnt];
                        out_im    <= mem_im[cnt];
                        out_last  <= (cnt == AW'(N_POINTS - 1));
                        cnt       <= cnt + AW'(1);
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample buffer: no reset, contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            mem_re[bitrev(cnt)] <= in_re;
            mem_im[bitrev(cnt)] <= in_im;
        end else if (state == S_COMPUTE) begin
            mem_re[top] <= top_re;
            mem_im[top] <= top_im;
            mem_re[bot] <= bot_re;
            mem_im[bot] <= bot_im;
        end
    end
endmodule

// File: tb/tb_fft_iter_core.sv
module tb_fft_iter_core;
    localparam int N  = 8;
    localparam int DW = 9;

    typedef int arr_t [N];
    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inv = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_re, out_im;
    logic          out_last;
    logic          busy;

    fft_iter_core #(.N_POINTS(N), .DATA_W(DW), .TW_W(8)) dut (
        .clk(clk), .rst(rst), .inv(inv),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   first_vld = 0;
    bit   want_lat = 0;

    task automatic count_cycles();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Scoreboard: every output handshake pops and compares one expectation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (want_lat && rst && out_valid) begin
                first_vld = cyc;
                want_lat  = 0;
            end
            if (rst && out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got re=%0d im=%0d with nothing expected",
                             $signed(out_re), $signed(out_im));
                end else begin
                    e = sbq.pop_front();
                    pops++;
                    if (out_re !== DW'(e.re) || out_im !== DW'(e.im) || out_last !== e.last) begin
                        errors++;
                        $display("FAIL out_sample: got re=%0d im=%0d last=%0b, want re=%0d im=%0d last=%0b",
                                 $signed(out_re), $signed(out_im), out_last, e.re, e.im, e.last);
                    end
                end
            end
        end
    endtask

    task automatic push_exp(input arr_t r, input arr_t i);
        pops = 0;
        for (int n = 0; n < N; n++) sbq.push_back('{r[n], i[n], (n == N - 1)});
    endtask

    // inv is driven to the requested value only with sample 0 and flipped
    // afterwards, so the frame must use the value latched at the start.
    task automatic drive_frame(input arr_t r, input arr_t i, input bit finv);
        int tmo;
        for (int n = 0; n < N; n++) begin
            in_valid = 1'b1;
            in_re    = DW'(r[n]);
            in_im    = DW'(i[n]);
            inv      = (n == 0) ? finv : ~finv;
            tmo = 0;
            @(negedge clk);
            while (!in_ready && tmo < 200) begin
                tmo++;
                @(negedge clk);
            end
            if (tmo >= 200) begin
                checks++;
                errors++;
                $display("FAIL in_accept_timeout: sample %0d never accepted", n);
            end
            @(posedge clk);
            #1;
        end
        last_acc = cyc;
        in_valid = 1'b0;
        inv      = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int tmo = 0;
        while ((sbq.size() != 0 || busy) && tmo < 400) begin
            @(negedge clk);
            tmo++;
        end
        checks++;
        if (tmo >= 400 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs missing, in_ready=%b, want 0 missing and in_ready=1",
                     name, sbq.size(), in_ready);
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_flags: out_valid=%b out_last=%b, want 0 0", out_valid, out_last);
        end
        checks++;
        if (out_re !== '0 || out_im !== '0) begin
            errors++;
            $display("FAIL reset_out_data: re=%0d im=%0d, want 0 0", $signed(out_re), $signed(out_im));
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_impulse();
        arr_t r  = '{8, 0, 0, 0, 0, 0, 0, 0};
        arr_t z  = '{0, 0, 0, 0, 0, 0, 0, 0};
        arr_t er = '{8, 8, 8, 8, 8, 8, 8, 8};
        push_exp(er, z);
        drive_frame(r, z, 1'b0);
        wait_drain("impulse");
    endtask

    // Also checks latency and that inputs are refused while computing.
    task automatic test_constant();
        arr_t r  = '{2, 2, 2, 2, 2, 2, 2, 2};
        arr_t z  = '{0, 0, 0, 0, 0, 0, 0, 0};
        arr_t er = '{16, 0, 0, 0, 0, 0, 0, 0};
        push_exp(er, z);
        drive_frame(r, z, 1'b0);
        want_lat = 1;
        in_valid = 1'b1;
        in_re    = DW'(100);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL compute_ctrl: cycle %0d in_ready=%b busy=%b, want 0 1", c, in_ready, busy);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_re    = '0;
        wait_drain("constant");
        checks++;
        if (first_vld - last_acc !== 13) begin
            errors++;
            $display("FAIL latency: got %0d cycles, want 13", first_vld - last_acc);
        end
    endtask

    task automatic test_alternating();
        arr_t r  = '{2, 0, 2, 0, 2, 0, 2, 0};
        arr_t z  = '{0, 0, 0, 0, 0, 0, 0, 0};
        arr_t er = '{8, 0, 0, 0, 8, 0, 0, 0};
        push_exp(er, z);
        drive_frame(r, z, 1'b0);
        wait_drain("alternating");
    endtask

    task automatic test_inverse();
        arr_t r1 = '{16, 0, 0, 0, 0, 0, 0, 0};
        arr_t r2 = '{2, 2, 2, 2, 2, 2, 2, 2};
        arr_t z  = '{0, 0, 0, 0, 0, 0, 0, 0};
        arr_t e1 = '{2, 2, 2, 2, 2, 2, 2, 2};
        arr_t e2 = '{2, 0, 0, 0, 0, 0, 0, 0};
        push_exp(e1, z);
        drive_frame(r1, z, 1'b1);
        wait_drain("inverse_impulse");
        push_exp(e2, z);
        drive_frame(r2, z, 1'b1);
        wait_drain("inverse_const");
    endtask

    task automatic test_saturation();
        arr_t r  = '{255, 255, 255, 255, 255, 255, 255, 255};
        arr_t z  = '{0, 0, 0, 0, 0, 0, 0, 0};
        arr_t er = '{255, 0, 0, 0, 0, 0, 0, 0};
        push_exp(er, z);
        drive_frame(r, z, 1'b0);
        wait_drain("sat_fwd");
        push_exp(er, z);
        drive_frame(r, z, 1'b1);
        wait_drain("sat_inv");
    endtask

    // Delayed impulses exercise every non-trivial twiddle, forward and conjugate.
    // The forward frame also stalls the output at index 3 for three cycles.
    task automatic test_twiddle();
        arr_t r   = '{0, 8, 0, 0, 0, 0, 0, 0};
        arr_t z   = '{0, 0, 0, 0, 0, 0, 0, 0};
        arr_t efr = '{8, 5, 0, -6, -8, -5, 0, 6};
        arr_t efi = '{0, -6, -8, -6, 0, 6, 8, 6};
        arr_t eir = '{1, 0, 0, -1, -1, -1, 0, 1};
        arr_t eii = '{0, 0, 1, 0, 0, -1, -1, -1};
        arr_t ejr = '{0, 5, 8, 5, 0, -5, -8, -5};
        arr_t eji = '{8, 5, 0, -6, -8, -5, 0, 6};
        int tmo = 0;
        push_exp(efr, efi);
        drive_frame(r, z, 1'b0);
        while (pops < 3 && tmo < 200) begin
            @(posedge clk);
            tmo++;
        end
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_re !== DW'(efr[3]) || out_im !== DW'(efi[3]) ||
                out_last !== 1'b0 || pops !== 3) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b re=%0d im=%0d last=%b popped=%0d, want 1 %0d %0d 0 3",
                         c, out_valid, $signed(out_re), $signed(out_im), out_last, pops, efr[3], efi[3]);
            end
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        wait_drain("twiddle_fwd");
        push_exp(eir, eii);
        drive_frame(r, z, 1'b1);
        wait_drain("twiddle_inv");
        push_exp(ejr, eji);
        drive_frame(z, r, 1'b0);
        wait_drain("twiddle_imag");
    endtask

    task automatic test_reset_mid();
        arr_t r = '{2, 2, 2, 2, 2, 2, 2, 2};
        arr_t z = '{0, 0, 0, 0, 0, 0, 0, 0};
        drive_frame(r, z, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     in_ready, out_valid, busy);
        end
        @(posedge clk);
        #1;
        test_impulse();
    endtask

    initial begin
        fork
            count_cycles();
            monitor();
        join_none
        test_reset();
        test_impulse();
        test_constant();
        test_alternating();
        test_inverse();
        test_saturation();
        test_twiddle();
        test_reset_mid();
        repeat (5) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected outputs never seen, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
